// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared state type and funct3 op codes for the M-extension unit
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// rtl/muldiv_unit_div_iter.sv - restoring unsigned divider, one quotient bit per step
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo_next,
    output logic [WIDTH-1:0] rem_next,
    output logic             last
);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [5:0]       cnt_q;
    logic [WIDTH:0]   trial;

    // Borrow out of the 33-bit trial subtraction means the shifted remainder was smaller.
    assign trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    assign rem_next = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    assign last     = (cnt_q == 6'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q + 6'd1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M multiply/divide unit with single-cycle multiply and iterative divide
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               funct3,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    input  logic [ADDRESS_WIDTH-1:0] rd_in,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    output logic [ADDRESS_WIDTH-1:0] rd_out
);

    state_t state_q, state_d;

    logic [2:0]               f3_q;
    logic [DATA_WIDTH-1:0]    a_q, b_q;
    logic [ADDRESS_WIDTH-1:0] rd_q;
    logic                     neg_quo_q, neg_rem_q;

    logic accept, div_signed, div_zero, div_ovf, special;
    logic [DATA_WIDTH-1:0] special_res;

    assign accept     = (state_q == IDLE) && start;
    assign div_signed = ~funct3[0];
    assign div_zero   = (op_b == 32'd0);
    assign div_ovf    = div_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    assign special    = funct3[2] && (div_zero || div_ovf);

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = funct3[1] ? op_a : 32'hFFFF_FFFF;
        else if (div_ovf)
            special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    logic signed [32:0] mul_a, mul_b;
    logic        [63:0] prod;
    logic [DATA_WIDTH-1:0] mul_res;

    assign mul_a   = {(f3_q == F3_MULH || f3_q == F3_MULHSU) && a_q[31], a_q};
    assign mul_b   = {(f3_q == F3_MULH) && b_q[31], b_q};
    assign prod    = 64'(mul_a) * 64'(mul_b);
    assign mul_res = (f3_q == F3_MUL) ? prod[31:0] : prod[63:32];

    logic [DATA_WIDTH-1:0] quo_next, rem_next, div_res;
    logic                  div_last;

    div_iter #(.WIDTH(DATA_WIDTH)) u_div_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && funct3[2]),
        .step     (state_q == DIV),
        .dividend (magnitude(op_a, div_signed)),
        .divisor  (magnitude(op_b, div_signed)),
        .quo_next (quo_next),
        .rem_next (rem_next),
        .last     (div_last)
    );

    // Quotient sign follows operand sign mismatch; remainder sign follows the dividend.
    assign div_res = f3_q[1] ? (neg_rem_q ? (~rem_next + 32'd1) : rem_next)
                             : (neg_quo_q ? (~quo_next + 32'd1) : quo_next);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!funct3[2])  state_d = MUL;
                    else if (special) state_d = DONE;
                    else              state_d = DIV;
                end
            end
            MUL:     state_d = DONE;
            DIV:     if (div_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            f3_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result    <= '0;
            rd_out    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                f3_q      <= funct3;
                a_q       <= op_a;
                b_q       <= op_b;
                rd_q      <= rd_in;
                neg_quo_q <= div_signed && (op_a[31] ^ op_b[31]);
                neg_rem_q <= div_signed && op_a[31];
                if (special) begin
                    result <= special_res;
                    rd_out <= rd_in;
                end
            end
            if (state_q == MUL) begin
                result <= mul_res;
                rd_out <= rd_q;
            end
            if (state_q == DIV && div_last) begin
                result <= div_res;
                rd_out <= rd_q;
            end
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    muldiv_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          at;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_rd"}, 32'(rd_out), 32'(e.rd));
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=%b expected 0 within 100 cycles", busy);
        end
    endtask

    // lat = edges after acceptance until the DONE state is entered
    task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int lat);
        int n;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        sb.push_back('{exp, rd, cyc + 1 + lat, nm});
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        rd_in  = 5'($urandom);
        check({nm, "_busy_k"}, 32'(busy), 32'd1);
        wait_idle(n);
        check({nm, "_busy_len"}, 32'(n), 32'(lat + 1));
    endtask

    int n;

    initial begin
        rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", 32'(rd_out), 32'd0);
        rst = 1'b0;

        issue("mul",      3'b000, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 1);
        issue("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 1);
        issue("mulh",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 1);
        issue("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'd2,         5'd4,  32'hFFFF_FFFF, 1);
        issue("div",      3'b100, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFD, 32);
        issue("rem",      3'b110, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 32);
        issue("divu",     3'b101, 32'd100,       32'd7,         5'd7,  32'd14,        32);
        issue("remu",     3'b111, 32'd100,       32'd7,         5'd0,  32'd2,         32);
        issue("div_neg",  3'b100, 32'd20,        32'hFFFF_FFFA, 5'd8,  32'hFFFF_FFFD, 32);
        issue("rem_neg",  3'b110, 32'd20,        32'hFFFF_FFFA, 5'd9,  32'd2,         32);
        issue("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         32);
        issue("remu_big", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 32);
        issue("divu_z",   3'b101, 32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF, 0);
        issue("rem_z",    3'b110, 32'd5,         32'd0,         5'd13, 32'd5,         0);
        issue("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 0);
        issue("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0,         0);

        // start pulses during divide iteration 5 and during DONE must be ignored
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3;
        sb.push_back('{32'd14, 5'd3, cyc + 33, "ign_divu"});
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd3; rd_in = 5'd9;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy_after_done", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("ign_busy_later", 32'(busy), 32'd0);
        check("ign_rd_held", 32'(rd_out), 32'd3);

        // reset in the middle of a divide abandons it silently
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; op_a = 32'hFFFF_FFF9; op_b = 32'd2; rd_in = 5'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_rd", 32'(rd_out), 32'd0);
        repeat (40) @(negedge clk);
        issue("post_rst_div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd17, 32'hFFFF_FFFD, 32);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; the design SHALL support only 32 (RV32M).
REQ-002 Parameter ADDRESS_WIDTH, default 5, destination-register tag width.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 op_a  input  DATA_WIDTH  rs1 operand (regfile RD1).
REQ-008 op_b  input  DATA_WIDTH  rs2 operand (regfile RD2).
REQ-009 rd_in  input  ADDRESS_WIDTH  destination tag of the request.
REQ-010 busy  output  1  high whenever state != IDLE.
REQ-011 done  output  1  one-cycle pulse, result and rd_out valid (drives regfile WE3/WD3 path).
REQ-012 result  output  DATA_WIDTH  completed value, held until the next completion or reset.
REQ-013 rd_out  output  ADDRESS_WIDTH  rd_in captured at start acceptance, held like result.

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV, DONE; IDLE->MUL (start, funct3[2]=0), IDLE->DIV (start, funct3[2]=1, normal case), IDLE->DONE (start, divide special case), MUL->DONE, DIV->DONE after 32 iterations, DONE->IDLE unconditionally.
REQ-015 At start acceptance (edge k) op_a, op_b, funct3, rd_in SHALL be registered; later input changes SHALL NOT affect the operation.
REQ-016 Multiply: 64-bit product of sign-/zero-extended operands per funct3 (MULHSU: op_a signed, op_b unsigned); MUL returns bits [31:0], MULH/MULHSU/MULHU return [63:32].
REQ-017 Multiply latency: state MUL after edge k, DONE after edge k+1, done high in cycle after edge k+1.
REQ-018 Divide: unsigned restoring division on magnitudes, one quotient bit per cycle, 6-bit iteration counter 0..31; DIV state for exactly 32 cycles, DONE after edge k+32.
REQ-019 Signed ops: quotient negated when operand signs differ; remainder takes sign of dividend.
REQ-020 Divide by zero (op_b=0): quotient 0xFFFFFFFF, remainder = op_a, signed or unsigned; DONE after edge k+1.
REQ-021 Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): quotient 0x80000000, remainder 0; DONE after edge k+1.
REQ-022 start while state != IDLE (including DONE) SHALL be ignored with no effect on the running op.
REQ-023 done SHALL be high for exactly one cycle per accepted request, never otherwise.
REQ-024 rd_out=0 requests SHALL complete normally; discarding x0 writes is the regfile/writeback responsibility.

Reset
REQ-025 rst high at any edge SHALL force IDLE, busy=0, done=0, result=0, rd_out=0, counter=0, abandoning any in-flight op without a done pulse.
REQ-026 rst SHALL take priority over start in the same cycle; start is accepted in the first cycle with rst low.

Structure
REQ-027 Package muldiv_pkg SHALL hold the state enum type and the eight funct3 localparam op codes, shared with the decoder.
REQ-028 The iterative restoring divider datapath (remainder/quotient shift registers, counter) SHALL be a sub-module div_iter; the multiplier, sign fix-up and FSM stay in muldiv_unit.

Verification
REQ-029 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done in cycle after edge k+1, busy high cycles k..k+1 only.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-031 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF, DIVU 100/7 -> 14, REMU -> 2; done exactly after edge k+32.
REQ-032 DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each done after edge k+1.
REQ-033 start pulsed during DIV iteration 5 and during DONE -> ignored, single done, rd_out unchanged.
REQ-034 rst at DIV iteration 10 -> next cycle busy=0, done=0, result=0, no later done; new start then completes correctly.
